// File: rtl/mem_playback.sv
`default_nettype none
// ============================================================================
// Module      : mem_playback
// Description : Playback RAM. Words are loaded from the register file, then
//               streamed to the DSP one word per enable strobe.
//               Optional XOR checksum: define MEM_PLAYBACK_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_playback #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_write,
    input  logic [NB_ADDR-1:0] i_address,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [NB_ADDR-1:0] i_length,
    input  logic               i_loop,
    input  logic               i_run,
    input  logic               i_enable,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_checksum
);

    localparam int                 c_DEPTH = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] c_ONE   = {{(NB_ADDR-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_ADDR-1:0] r_rd_ptr;
    logic [NB_ADDR-1:0] w_rd_ptr_next;
    logic [NB_ADDR-1:0] r_len_q;
    logic [NB_ADDR-1:0] w_len_next;
    logic               r_write_q;
    logic               r_run_q;
    logic               r_valid;
    logic [NB_DATA-1:0] r_rdata;
    logic [NB_DATA-1:0] r_mem [c_DEPTH];

    logic w_write_rise;
    logic w_run_rise;
    logic w_wr_en;
    logic w_rd_en;
    logic w_start;

    assign w_write_rise = i_write & ~r_write_q;
    assign w_run_rise   = i_run & ~r_run_q;
    // Writes while streaming are dropped; the register file must poll o_busy.
    assign w_wr_en      = w_write_rise & (r_state != ST_PLAY) & ~rst;

    always_comb begin
        w_state_next  = r_state;
        w_rd_ptr_next = r_rd_ptr;
        w_len_next    = r_len_q;
        w_rd_en       = 1'b0;
        w_start       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_run_rise) begin
                    w_state_next  = ST_PLAY;
                    w_rd_ptr_next = '0;
                    w_len_next    = i_length;
                    w_start       = 1'b1;
                end
            end
            ST_PLAY: begin
                // Abort wins over a coincident enable: no read in that cycle.
                if (!i_run) begin
                    w_state_next = ST_IDLE;
                end else if (i_enable) begin
                    w_rd_en = 1'b1;
                    if (r_rd_ptr == r_len_q) begin
                        if (i_loop) begin
                            w_rd_ptr_next = '0;
                        end else begin
                            w_state_next = ST_DONE;
                        end
                    end else begin
                        w_rd_ptr_next = r_rd_ptr + c_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (!i_run) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rd_ptr  <= '0;
            r_len_q   <= '0;
            r_write_q <= 1'b0;
            r_run_q   <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rd_ptr  <= w_rd_ptr_next;
            r_len_q   <= w_len_next;
            r_write_q <= i_write;
            r_run_q   <= i_run;
            r_valid   <= w_rd_en;
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[i_address] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rdata <= r_mem[r_rd_ptr];
        end
    end

    assign o_data  = r_rdata;
    assign o_valid = r_valid;
    assign o_busy  = (r_state == ST_PLAY);
    assign o_done  = (r_state == ST_DONE);

`ifdef MEM_PLAYBACK_CHECKSUM_EN
    logic [NB_DATA-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (r_valid) begin
            r_checksum <= r_checksum ^ r_rdata;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = '0;
`endif

endmodule
`default_nettype wire
